// File: rtl/rf_writeback_queue.sv
// Purpose : merges two writeback producers (A = ALU, B = memory) into one in-order
//           FIFO that drains one entry per cycle into the register-file write port.
// Latency : an entry enqueued at edge N can drive wr in the cycle after edge N. There
//           is no bypass when the FIFO is empty.
// Backpres: ready_a/ready_b come from the registered count only. B needs two free
//           slots so that A and B can both be accepted in the same cycle.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   valid_a/addr_a/data_a      producer A result; ready_a = accepted this cycle
//   valid_b/addr_b/data_b      producer B result; ready_b = accepted this cycle
//   hold                       stall the drain for this cycle
//   wr/addr_d/data_in          register-file write port; data is the FIFO head
//   lk_addr/lk_hit/lk_data     youngest pending value for lk_addr (forwarding)
//   count                      occupied entries
module rf_writeback_queue #(
  parameter int LENGTH       = 32,
  parameter int NREGS        = 8,
  parameter int SEL_BITS     = $clog2(NREGS),
  parameter int DEPTH        = 4,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_a,
  input  logic [SEL_BITS-1:0]        addr_a,
  input  logic [LENGTH-1:0]          data_a,
  output logic                       ready_a,
  input  logic                       valid_b,
  input  logic [SEL_BITS-1:0]        addr_b,
  input  logic [LENGTH-1:0]          data_b,
  output logic                       ready_b,
  input  logic                       hold,
  output logic                       wr,
  output logic [SEL_BITS-1:0]        addr_d,
  output logic [LENGTH-1:0]          data_in,
  input  logic [SEL_BITS-1:0]        lk_addr,
  output logic                       lk_hit,
  output logic [LENGTH-1:0]          lk_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_A_MAX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_B_MAX = CW'(DEPTH - 2);

  logic [SEL_BITS-1:0] mem_addr [DEPTH];
  logic [LENGTH-1:0]   mem_data [DEPTH];
  logic [DEPTH-1:0]    mem_vld;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       ptr_b;

  logic empty;
  logic pop;
  logic push_a;
  logic push_b;

  assign ready_a = (count <= CNT_A_MAX);
  assign ready_b = (count <= CNT_B_MAX);

  // Writes to r0 still complete their handshake; they just never occupy a slot.
  assign push_a = valid_a && ready_a && !(R0_HARDWIRED && (addr_a == '0));
  assign push_b = valid_b && ready_b && !(R0_HARDWIRED && (addr_b == '0));

  // B lands behind A when both are accepted in the same cycle.
  assign ptr_b = wr_ptr + PW'(push_a);

  assign empty   = (count == '0);
  assign pop     = !empty && !hold;
  assign wr      = pop;
  assign addr_d  = empty ? '0 : mem_addr[rd_ptr];
  assign data_in = empty ? '0 : mem_data[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      mem_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      // A push never targets the slot being popped: that would need count==DEPTH,
      // where both readies are low.
      if (pop) begin
        mem_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push_a) begin
        mem_vld[wr_ptr]  <= 1'b1;
        mem_addr[wr_ptr] <= addr_a;
        mem_data[wr_ptr] <= data_a;
      end
      if (push_b) begin
        mem_vld[ptr_b]  <= 1'b1;
        mem_addr[ptr_b] <= addr_b;
        mem_data[ptr_b] <= data_b;
      end
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  // Scan from oldest to youngest so the last match wins. The head being popped this
  // cycle is still valid here, so it can still be forwarded.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_vld[rd_ptr + PW'(i)] && (mem_addr[rd_ptr + PW'(i)] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = mem_data[rd_ptr + PW'(i)];
      end
    end
    if (R0_HARDWIRED && (lk_addr == '0)) begin
      lk_hit  = 1'b0;
      lk_data = '0;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!reset) count <= CNT_FULL);

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: a vector table for single-cycle behaviour,
// plus hand-written sequences for async reset and a scoreboarded wrap/overlap run.
module tb_rf_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_a, valid_b, hold;
  logic [2:0]  addr_a, addr_b, lk_addr;
  logic [31:0] data_a, data_b;
  logic        ready_a, ready_b, wr, lk_hit;
  logic [2:0]  addr_d, count;
  logic [31:0] data_in, lk_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_writeback_queue dut (
    .clk(clk), .reset(reset),
    .valid_a(valid_a), .addr_a(addr_a), .data_a(data_a), .ready_a(ready_a),
    .valid_b(valid_b), .addr_b(addr_b), .data_b(data_b), .ready_b(ready_b),
    .hold(hold), .wr(wr), .addr_d(addr_d), .data_in(data_in),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data), .count(count)
  );

  typedef struct {
    logic va; logic [2:0] aa; logic [31:0] da;
    logic vb; logic [2:0] ab; logic [31:0] db;
    logic hold; logic [2:0] lk;
    logic ra; logic rb; logic wr; logic [2:0] ad; logic [31:0] di;
    logic hit; logic [31:0] ld; logic [2:0] cnt;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(
    input logic va, input logic [2:0] aa, input logic [31:0] da,
    input logic vb, input logic [2:0] ab, input logic [31:0] db,
    input logic hd, input logic [2:0] lk,
    input logic ra, input logic rb, input logic w, input logic [2:0] ad,
    input logic [31:0] di, input logic hit, input logic [31:0] ld, input logic [2:0] cnt);
    vec_t v;
    v.va = va; v.aa = aa; v.da = da; v.vb = vb; v.ab = ab; v.db = db;
    v.hold = hd; v.lk = lk; v.ra = ra; v.rb = rb; v.wr = w; v.ad = ad;
    v.di = di; v.hit = hit; v.ld = ld; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_a = 1'b0; addr_a = '0; data_a = '0;
    valid_b = 1'b0; addr_b = '0; data_b = '0;
    hold = 1'b0; lk_addr = '0;
  endtask

  // scoreboard state
  logic [34:0] sb[$];
  int          mcnt;
  int          pushed;
  int          written;
  int          seq;
  logic [2:0]  a_ad, b_ad;
  logic [31:0] a_dt, b_dt;

  task automatic sb_cycle(input logic va, input logic vb, input logic hd, input int cyc);
    logic era, erb, ewr;
    @(posedge clk); #1;
    valid_a = va; addr_a = a_ad; data_a = a_dt;
    valid_b = vb; addr_b = b_ad; data_b = b_dt;
    hold = hd; lk_addr = '0;
    #1;
    era = (mcnt <= 3);
    erb = (mcnt <= 2);
    ewr = (mcnt != 0) && !hd;
    chk($sformatf("sb%0d.count", cyc), count, mcnt);
    chk($sformatf("sb%0d.count_le_depth", cyc), (count <= 3'd4), 1);
    chk($sformatf("sb%0d.ready_a", cyc), ready_a, era);
    chk($sformatf("sb%0d.ready_b", cyc), ready_b, erb);
    chk($sformatf("sb%0d.wr", cyc), wr, ewr);
    if (ewr && sb.size() > 0) begin
      chk($sformatf("sb%0d.write", cyc), {addr_d, data_in}, sb[0]);
      void'(sb.pop_front());
      written++;
    end
    if (va && era) begin
      sb.push_back({a_ad, a_dt});
      pushed++; seq++;
      a_ad = 3'(1 + (seq % 7)); a_dt = 32'h1000_0000 + seq;
    end
    if (vb && erb) begin
      sb.push_back({b_ad, b_dt});
      pushed++; seq++;
      b_ad = 3'(1 + (seq % 7)); b_dt = 32'h2000_0000 + seq;
    end
    mcnt = mcnt + int'(va && era) + int'(vb && erb) - int'(ewr);
  endtask

  initial begin
    vecs[0]  = mk(1,3,32'hDEADBEEF,0,0,0,0,3, 1,1,0,0,0,0,0,0);
    vecs[1]  = mk(0,0,0,0,0,0,0,3, 1,1,1,3,32'hDEADBEEF,1,32'hDEADBEEF,1);
    vecs[2]  = mk(0,0,0,0,0,0,0,3, 1,1,0,0,0,0,0,0);
    vecs[3]  = mk(1,2,32'h11,1,2,32'h22,0,2, 1,1,0,0,0,0,0,0);
    vecs[4]  = mk(0,0,0,0,0,0,0,2, 1,1,1,2,32'h11,1,32'h22,2);
    vecs[5]  = mk(0,0,0,0,0,0,0,2, 1,1,1,2,32'h22,1,32'h22,1);
    vecs[6]  = mk(0,0,0,0,0,0,0,2, 1,1,0,0,0,0,0,0);
    vecs[7]  = mk(1,0,32'h55,0,0,0,0,0, 1,1,0,0,0,0,0,0);
    vecs[8]  = mk(0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0);
    vecs[9]  = mk(1,1,32'hA1,0,0,0,1,1, 1,1,0,0,0,0,0,0);
    vecs[10] = mk(1,4,32'hA2,0,0,0,1,1, 1,1,0,1,32'hA1,1,32'hA1,1);
    vecs[11] = mk(1,1,32'hA3,0,0,0,1,1, 1,1,0,1,32'hA1,1,32'hA1,2);
    vecs[12] = mk(1,5,32'hA4,0,0,0,1,1, 1,0,0,1,32'hA1,1,32'hA3,3);
    vecs[13] = mk(1,6,32'hBAD,1,7,32'hB0B,1,1, 0,0,0,1,32'hA1,1,32'hA3,4);
    vecs[14] = mk(1,6,32'hBAD,0,0,0,0,6, 0,0,1,1,32'hA1,0,0,4);
    vecs[15] = mk(0,0,0,0,0,0,0,5, 1,0,1,4,32'hA2,1,32'hA4,3);
    vecs[16] = mk(0,0,0,0,0,0,0,1, 1,1,1,1,32'hA3,1,32'hA3,2);
    vecs[17] = mk(0,0,0,0,0,0,0,5, 1,1,1,5,32'hA4,1,32'hA4,1);
    vecs[18] = mk(0,0,0,0,0,0,0,7, 1,1,0,0,0,0,0,0);
    vecs[19] = mk(1,3,32'h33,0,0,0,0,3, 1,1,0,0,0,0,0,0);
    vecs[20] = mk(1,4,32'h44,0,0,0,0,3, 1,1,1,3,32'h33,1,32'h33,1);
    vecs[21] = mk(0,0,0,0,0,0,0,4, 1,1,1,4,32'h44,1,32'h44,1);
    vecs[22] = mk(0,0,0,0,0,0,0,4, 1,1,0,0,0,0,0,0);
    vecs[23] = mk(1,2,32'h99,1,0,32'h77,0,0, 1,1,0,0,0,0,0,0);
    vecs[24] = mk(0,0,0,0,0,0,0,2, 1,1,1,2,32'h99,1,32'h99,1);
    vecs[25] = mk(0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0);

    // reset state
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.wr", wr, 0);
    chk("rst.count", count, 0);
    chk("rst.addr_d", addr_d, 0);
    chk("rst.data_in", data_in, 0);
    chk("rst.lk_hit", lk_hit, 0);
    chk("rst.ready_a", ready_a, 1);
    chk("rst.ready_b", ready_b, 1);
    @(negedge clk);
    reset = 1'b1;

    // table-driven vectors: inputs applied after the edge, outputs checked mid-cycle
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      valid_a = vecs[i].va; addr_a = vecs[i].aa; data_a = vecs[i].da;
      valid_b = vecs[i].vb; addr_b = vecs[i].ab; data_b = vecs[i].db;
      hold = vecs[i].hold; lk_addr = vecs[i].lk;
      #1;
      chk($sformatf("v%0d.ready_a", i), ready_a, vecs[i].ra);
      chk($sformatf("v%0d.ready_b", i), ready_b, vecs[i].rb);
      chk($sformatf("v%0d.wr", i), wr, vecs[i].wr);
      chk($sformatf("v%0d.addr_d", i), addr_d, vecs[i].ad);
      chk($sformatf("v%0d.data_in", i), data_in, vecs[i].di);
      chk($sformatf("v%0d.lk_hit", i), lk_hit, vecs[i].hit);
      chk($sformatf("v%0d.lk_data", i), lk_data, vecs[i].ld);
      chk($sformatf("v%0d.count", i), count, vecs[i].cnt);
    end

    // asynchronous reset in the middle of a cycle with entries pending
    @(posedge clk); #1;
    idle_inputs();
    hold = 1'b1;
    valid_a = 1'b1; addr_a = 3'd3; data_a = 32'hC1;
    valid_b = 1'b1; addr_b = 3'd5; data_b = 32'hC2;
    @(posedge clk); #1;
    idle_inputs();
    lk_addr = 3'd5;
    #1;
    chk("arst.pre_count", count, 2);
    chk("arst.pre_wr", wr, 1);
    chk("arst.pre_lk_hit", lk_hit, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst.wr", wr, 0);
    chk("arst.count", count, 0);
    chk("arst.lk_hit", lk_hit, 0);
    chk("arst.addr_d", addr_d, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("arst.ready_a", ready_a, 1);
    chk("arst.ready_b", ready_b, 1);
    chk("arst.post_count", count, 0);

    // sustained A/B traffic with hold toggling; scoreboard checks write order
    mcnt = 0; pushed = 0; written = 0; seq = 0;
    a_ad = 3'd1; a_dt = 32'h1000_0000;
    b_ad = 3'd2; b_dt = 32'h2000_0001;
    seq = 1;
    for (int c = 0; c < 40; c++)
      sb_cycle((c % 4) != 3, (c % 3) != 1, ((c / 3) % 3) == 2, c);
    for (int c = 40; c < 52 && mcnt != 0; c++)
      sb_cycle(1'b0, 1'b0, 1'b0, c);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("sb.final_count", count, 0);
    chk("sb.queue_empty", sb.size(), 0);
    chk("sb.enough_entries", (pushed > 12), 1);
    chk("sb.written_all", written, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
